// File: rtl/clk_div_monitor.sv
// Receive-side checker for even clock dividers: measures high time, low time and period of
// clk_div in clk_in cycles and reports match, lock, sticky error and stall status.
module clk_div_monitor #(
  parameter int CW      = 8,
  parameter int TIMEOUT = 200,
  parameter int LOCK_N  = 4
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          clk_div,
  input  logic [CW-1:0] exp_ratio,
  input  logic          err_clr,
  output logic          meas_valid,
  output logic [CW-1:0] meas_high,
  output logic [CW-1:0] meas_low,
  output logic [CW:0]   meas_period,
  output logic          match,
  output logic          locked,
  output logic          err,
  output logic          stall,
  output logic [1:0]    dbg_state
);

  localparam int            LW       = $clog2(LOCK_N + 1);
  localparam logic [CW-1:0] TO_VAL   = CW'(TIMEOUT);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_N);

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          s_q, s_d;
  logic          rise, fall;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] lcnt_q, lcnt_d;
  logic [LW-1:0] match_cnt_q;
  logic          publish, timeout;
  logic          is_match, err_set;
  logic [CW:0]   period_sum;

  // Edges are taken from the two-stage sample, so detection lags clk_div by one cycle.
  assign rise       = s_q & ~s_d;
  assign fall       = ~s_q & s_d;
  assign period_sum = {1'b0, hcnt_q} + {1'b0, lcnt_q};
  assign is_match   = (period_sum == {1'b0, exp_ratio}) && (hcnt_q == (exp_ratio >> 1));
  assign locked     = (match_cnt_q == LOCK_MAX);
  assign err_set    = locked && ((publish && !is_match) || timeout);
  assign dbg_state  = state_q;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    publish = 1'b0;
    timeout = 1'b0;
    case (state_q)
      WAIT_RISE: begin
        if (rise) begin
          hcnt_d  = CW'(1);
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          lcnt_d  = CW'(1);
          state_d = LOW;
        end else if (hcnt_q == TO_VAL) begin
          timeout = 1'b1;
          state_d = WAIT_RISE;
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
      LOW: begin
        if (rise) begin
          publish = 1'b1;
          hcnt_d  = CW'(1);
          state_d = HIGH;
        end else if (lcnt_q == TO_VAL) begin
          timeout = 1'b1;
          state_d = WAIT_RISE;
        end else begin
          lcnt_d = lcnt_q + CW'(1);
        end
      end
      default: state_d = WAIT_RISE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_RISE;
      s_q         <= 1'b0;
      s_d         <= 1'b0;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      match_cnt_q <= '0;
      meas_valid  <= 1'b0;
      meas_high   <= '0;
      meas_low    <= '0;
      meas_period <= '0;
      match       <= 1'b0;
      err         <= 1'b0;
      stall       <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= clk_div;
      s_d        <= s_q;
      hcnt_q     <= hcnt_d;
      lcnt_q     <= lcnt_d;
      meas_valid <= publish;
      if (publish) begin
        meas_high   <= hcnt_q;
        meas_low    <= lcnt_q;
        meas_period <= period_sum;
        match       <= is_match;
      end
      if (timeout) begin
        match_cnt_q <= '0;
      end else if (publish) begin
        if (!is_match) match_cnt_q <= '0;
        else if (match_cnt_q != LOCK_MAX) match_cnt_q <= match_cnt_q + LW'(1);
      end
      // stall only ever clears on the rise that restarts measurement.
      if (timeout) stall <= 1'b1;
      else if (state_q == WAIT_RISE && rise) stall <= 1'b0;
      if (err_set) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: drives divided-clock waveforms and compares every cycle against
// an edge-timestamp reference model of the measurement, lock, error and stall rules.
module tb_clk_div_monitor;

  localparam int CW      = 8;
  localparam int TIMEOUT = 200;
  localparam int LOCK_N  = 4;
  localparam int PW      = CW + 1;
  localparam int MW      = 2 * CW + PW;
  localparam int SW      = 5 + MW;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b1;
  logic          clk_div = 1'b0;
  logic [CW-1:0] exp_ratio = '0;
  logic          err_clr = 1'b0;
  logic          meas_valid;
  logic [CW-1:0] meas_high;
  logic [CW-1:0] meas_low;
  logic [CW:0]   meas_period;
  logic          match, locked, err, stall;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state: timestamps of detected edges, not counters
  bit m_p1, m_p2, m_have, m_valid, m_match, m_err, m_stall;
  int m_j = 0;
  int m_rise_t, m_fall_t, m_high, m_low, m_cnt;
  logic [MW-1:0] exp_q[$];
  bit lvl_q[$];

  always #5 clk_in = ~clk_in;

  clk_div_monitor #(.CW(CW), .TIMEOUT(TIMEOUT), .LOCK_N(LOCK_N)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .clk_div(clk_div), .exp_ratio(exp_ratio),
    .err_clr(err_clr), .meas_valid(meas_valid), .meas_high(meas_high), .meas_low(meas_low),
    .meas_period(meas_period), .match(match), .locked(locked), .err(err), .stall(stall),
    .dbg_state(dbg_state)
  );

  function automatic logic [SW-1:0] dut_status();
    return {meas_valid, match, locked, err, stall, meas_high, meas_low, meas_period};
  endfunction

  function automatic logic [SW-1:0] exp_status();
    return {m_valid, m_match, (m_cnt == LOCK_N), m_err, m_stall,
            CW'(m_high), CW'(m_low), PW'(m_high + m_low)};
  endfunction

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_have = 0; m_valid = 0; m_match = 0; m_err = 0; m_stall = 0;
    m_rise_t = 0; m_fall_t = -1; m_high = 0; m_low = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  // Asserts reset between clock edges and leaves it asserted.
  task automatic apply_reset();
    @(negedge clk_in);
    #2;
    rst_n = 1'b0; clk_div = 1'b0; err_clr = 1'b0;
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  task automatic do_reset();
    apply_reset();
    release_reset();
  endtask

  task automatic add_wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) lvl_q.push_back(1'b1);
      for (int i = 0; i < lo; i++) lvl_q.push_back(1'b0);
    end
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) lvl_q.push_back(1'b0);
  endtask

  // Drive one clock of stimulus (called at a negedge) and advance the reference model.
  task automatic tick(input bit v, input bit clr);
    bit rise_d, fall_d, pub, to, was_locked, good;
    clk_div = v; err_clr = clr;
    rise_d = m_p1 & ~m_p2;
    fall_d = ~m_p1 & m_p2;
    pub = 0; to = 0; good = 0;
    was_locked = (m_cnt == LOCK_N);
    if (!m_have) begin
      if (rise_d) begin
        m_have = 1; m_rise_t = m_j; m_fall_t = -1; m_stall = 0;
      end
    end else if (m_fall_t < 0) begin
      if (fall_d) m_fall_t = m_j;
      else if (m_j - m_rise_t == TIMEOUT) to = 1;
    end else if (rise_d) begin
      pub = 1;
      m_high = m_fall_t - m_rise_t;
      m_low = m_j - m_fall_t;
      m_rise_t = m_j;
      m_fall_t = -1;
    end else if (m_j - m_fall_t == TIMEOUT) begin
      to = 1;
    end
    m_valid = pub;
    if (pub) begin
      good = (m_high + m_low == int'(exp_ratio)) && (m_high == int'(exp_ratio) / 2);
      m_match = good;
      exp_q.push_back({CW'(m_high), CW'(m_low), PW'(m_high + m_low)});
      m_cnt = good ? ((m_cnt < LOCK_N) ? m_cnt + 1 : LOCK_N) : 0;
    end
    if (to) begin
      m_cnt = 0; m_stall = 1; m_have = 0;
    end
    if (was_locked && ((pub && !good) || to)) m_err = 1;
    else if (clr) m_err = 0;
    m_p2 = m_p1; m_p1 = v; m_j++;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if ({dut_status(), dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=0", {dut_status(), dbg_state});
    end
    release_reset();
    exp_ratio = 2;
    add_wave(1, 1, 5);
    while (lvl_q.size() != 0) tick(lvl_q.pop_front(), 1'b0);
    apply_reset();
    n_tests++;
    if ({dut_status(), dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run got=%h want=0", {dut_status(), dbg_state});
    end
    release_reset();
  endtask

  task automatic test_div2();
    int n_pulse = 0;
    bit seen_lock = 0;
    logic [MW-1:0] want;
    do_reset();
    exp_ratio = 2;
    add_idle($urandom_range(0, 3));
    add_wave(1, 1, 12);
    while (lvl_q.size() != 0) begin
      tick(lvl_q.pop_front(), 1'b0);
      n_tests++;
      if (dut_status() !== exp_status()) begin
        n_fail++;
        $display("FAIL div2_status edge=%0d got=%h want=%h", m_j, dut_status(), exp_status());
      end
      if (meas_valid) begin
        n_pulse++;
        n_tests++;
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if ({meas_high, meas_low, meas_period} !== want) begin
          n_fail++;
          $display("FAIL div2_meas edge=%0d got=%h want=%h", m_j,
                   {meas_high, meas_low, meas_period}, want);
        end
      end
      if (locked && !seen_lock) begin
        seen_lock = 1;
        n_tests++;
        if (n_pulse != LOCK_N) begin
          n_fail++;
          $display("FAIL div2_lock_count got=%0d want=%0d", n_pulse, LOCK_N);
        end
      end
    end
  endtask

  task automatic test_div8();
    logic [MW-1:0] want;
    do_reset();
    exp_ratio = 8;
    add_idle($urandom_range(0, 5));
    add_wave(4, 4, 8);
    while (lvl_q.size() != 0) begin
      tick(lvl_q.pop_front(), 1'b0);
      n_tests++;
      if (dut_status() !== exp_status()) begin
        n_fail++;
        $display("FAIL div8_status edge=%0d got=%h want=%h", m_j, dut_status(), exp_status());
      end
      if (meas_valid) begin
        n_tests++;
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if ({meas_high, meas_low, meas_period} !== want) begin
          n_fail++;
          $display("FAIL div8_meas edge=%0d got=%h want=%h", m_j,
                   {meas_high, meas_low, meas_period}, want);
        end
      end
    end
  endtask

  task automatic test_wrong_ratio();
    do_reset();
    exp_ratio = 4;
    add_idle($urandom_range(0, 5));
    add_wave(4, 4, 7);
    while (lvl_q.size() != 0) begin
      tick(lvl_q.pop_front(), 1'b0);
      n_tests++;
      if (dut_status() !== exp_status() || locked !== 1'b0) begin
        n_fail++;
        $display("FAIL wrong_ratio_status edge=%0d got=%h want=%h", m_j, dut_status(),
                 exp_status());
      end
    end
  endtask

  task automatic test_ratio_switch();
    int c = 0;
    int clr_at = $urandom_range(24, 30);
    do_reset();
    exp_ratio = 4;
    add_wave(2, 2, 10);
    add_wave(4, 4, 5);
    while (lvl_q.size() != 0) begin
      tick(lvl_q.pop_front(), (c == 40 + clr_at));
      c++;
      n_tests++;
      if (dut_status() !== exp_status()) begin
        n_fail++;
        $display("FAIL switch_status edge=%0d got=%h want=%h", m_j, dut_status(), exp_status());
      end
    end
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL switch_err_clr got=%b want=0", err);
    end
  endtask

  task automatic test_duty();
    do_reset();
    exp_ratio = 8;
    add_idle($urandom_range(0, 5));
    add_wave(3, 5, 7);
    while (lvl_q.size() != 0) begin
      tick(lvl_q.pop_front(), 1'b0);
      n_tests++;
      if (dut_status() !== exp_status() || locked !== 1'b0) begin
        n_fail++;
        $display("FAIL duty_status edge=%0d got=%h want=%h", m_j, dut_status(), exp_status());
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    exp_ratio = 4;
    add_wave(2, 2, 8);
    add_idle(TIMEOUT + 8);
    add_wave(2, 2, 5);
    lvl_q.push_back(1'b1);
    while (lvl_q.size() != 0) begin
      tick(lvl_q.pop_front(), 1'b0);
      n_tests++;
      if (dut_status() !== exp_status()) begin
        n_fail++;
        $display("FAIL stall_status edge=%0d got=%h want=%h", m_j, dut_status(), exp_status());
      end
    end
    apply_reset();
    n_tests++;
    if ({dut_status(), dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL stall_mid_reset got=%h want=0", {dut_status(), dbg_state});
    end
    release_reset();
  endtask

  task automatic test_random();
    int r, hi, lo;
    logic [MW-1:0] want;
    do_reset();
    for (int s = 0; s < 14; s++) begin
      r = 2 * $urandom_range(1, 6);
      hi = r / 2;
      lo = r / 2;
      if ($urandom_range(0, 3) == 0) begin
        if (hi > 1) begin hi--; lo++; end
        else lo++;
      end
      exp_ratio = ($urandom_range(0, 3) != 0) ? CW'(r) : CW'(2 * $urandom_range(1, 6));
      add_wave(hi, lo, $urandom_range(3, 8));
      if (s == 7) add_idle(TIMEOUT + $urandom_range(1, 6));
      while (lvl_q.size() != 0) begin
        tick(lvl_q.pop_front(), ($urandom_range(0, 15) == 0));
        n_tests++;
        if (dut_status() !== exp_status()) begin
          n_fail++;
          $display("FAIL random_status edge=%0d got=%h want=%h", m_j, dut_status(),
                   exp_status());
        end
        if (meas_valid) begin
          n_tests++;
          want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
          if ({meas_high, meas_low, meas_period} !== want) begin
            n_fail++;
            $display("FAIL random_meas edge=%0d got=%h want=%h", m_j,
                     {meas_high, meas_low, meas_period}, want);
          end
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_missing_meas got=%0d pending want=0", exp_q.size());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_div2();
    test_div8();
    test_wrong_ratio();
    test_ratio_switch();
    test_duty();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
